muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the EXU HI/LO path.
- Replaces the fixed 32-bit single-cycle product and divider instance inside the ALU.
- Accepts one MULT/MULTU/DIV/DIVU request via valid/ready and returns a {hi, lo} pair via valid/ready.
- Supports pipeline flush and configurable bits-per-cycle.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_div_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers for the iterative multiply/divide unit.
//   - MD_* : request opcodes carried on req_op
//   - ST_* : controller state encoding
//   - cnt_w(): width of the iteration counter, which must hold WIDTH/STEP
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int cnt_w(input int width, input int step);
    return $clog2(width / step + 1);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: combinational STEP-bit slice of a restoring divider.
//   rem_i : partial remainder (always < dvs_i)
//   dvd_i : dividend bits still to be consumed (MSB first); quotient bits
//           are shifted in at the bottom as dividend bits leave the top
//   dvs_i : divisor magnitude
//   rem_o / dvd_o : state after STEP quotient bits have been resolved
module muldiv_div_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;

  always_comb begin
    r = rem_i;
    d = dvd_i;
    t = '0;
    for (int s = 0; s < STEP; s++) begin
      // remainder < divisor, so the shifted trial value fits in WIDTH+1 bits
      t = {r, d[WIDTH-1]};
      d = {d[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, dvs_i}) begin
        t    = t - {1'b0, dvs_i};
        d[0] = 1'b1;
      end
      r = t[WIDTH-1:0];
    end
    rem_o = r;
    dvd_o = d;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the HI/LO path.
//   clk, rst (async, active low)
//   req_valid/req_ready/req_op/src_a/src_b : request handshake, accepted only in IDLE
//   flush       : aborts MUL/DIV/DONE and blocks acceptance in IDLE
//   resp_valid/resp_ready/resp_hi/resp_lo  : {hi, lo} result, held while in DONE
//   stall_req   : EXU stall (request blocked, or response not yet taken)
// Build option MULDIV_FAST_MUL_EN: multiplies use a single combinational
// product in the one-cycle finalize stage instead of the shift-add loop.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             stall_req
);

  localparam int CW = cnt_w(WIDTH, STEP);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  // x: multiply -> shifted multiplicand; divide -> {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] x_q, x_d;
  // y: multiply -> multiplier shifting right; divide -> divisor
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               req_sgn, req_a_neg, req_b_neg;
  logic [WIDTH-1:0]   req_a_mag, req_b_mag;
  logic [2*WIDTH-1:0] p_nx, m_nx, mul_prod, mul_res;
  logic [WIDTH-1:0]   y_nx, rem_nx, dvd_nx, quo_f, rem_f, a_raw;
  logic               res_neg;

  assign req_sgn   = (req_op == MD_MULT) || (req_op == MD_DIV);
  assign req_a_neg = req_sgn & src_a[WIDTH-1];
  assign req_b_neg = req_sgn & src_b[WIDTH-1];
  assign req_a_mag = req_a_neg ? -src_a : src_a;
  assign req_b_mag = req_b_neg ? -src_b : src_b;

  // Shift-add: STEP multiplier bits per cycle, LSB first.
  always_comb begin
    p_nx = p_q;
    m_nx = x_q;
    y_nx = y_q;
    for (int s = 0; s < STEP; s++) begin
      if (y_nx[0]) p_nx = p_nx + m_nx;
      m_nx = m_nx << 1;
      y_nx = y_nx >> 1;
    end
  end

  muldiv_div_step #(.WIDTH(WIDTH), .STEP(STEP)) u_div_step (
    .rem_i (x_q[2*WIDTH-1:WIDTH]),
    .dvd_i (x_q[WIDTH-1:0]),
    .dvs_i (y_q),
    .rem_o (rem_nx),
    .dvd_o (dvd_nx)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign mul_prod = {{WIDTH{1'b0}}, x_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, y_q};
`else
  assign mul_prod = p_q;
`endif

  // Sign flags are only ever set for signed ops, so no op check is needed here.
  assign res_neg = a_neg_q ^ b_neg_q;
  assign mul_res = res_neg ? -mul_prod : mul_prod;
  assign quo_f   = res_neg ? -x_q[WIDTH-1:0] : x_q[WIDTH-1:0];
  assign rem_f   = a_neg_q ? -x_q[2*WIDTH-1:WIDTH] : x_q[2*WIDTH-1:WIDTH];
  // Divide-by-zero never iterates, so the low half still holds |src_a|.
  assign a_raw   = a_neg_q ? -x_q[WIDTH-1:0] : x_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = req_op;
          a_neg_d = req_a_neg;
          b_neg_d = req_b_neg;
          x_d     = {{WIDTH{1'b0}}, req_a_mag};
          y_d     = req_b_mag;
          p_d     = '0;
          if (req_op[1]) begin
            state_d = ST_DIV;
            cnt_d   = (src_b == '0) ? '0 : CW'(WIDTH / STEP);
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            // Straight to the single finalize cycle, which holds the product.
            state_d = ST_DIV;
            cnt_d   = '0;
`else
            state_d = ST_MUL;
            cnt_d   = CW'(WIDTH / STEP);
`endif
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (state_q == ST_MUL) begin
            p_d = p_nx;
            x_d = m_nx;
            y_d = y_nx;
          end else begin
            x_d = {rem_nx, dvd_nx};
          end
        end else begin
          // Finalize: sign fix-up on the way into DONE.
          state_d = ST_DONE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = mul_res;
          end else if (y_q == '0) begin
            hi_d = a_raw;
            lo_d = '1;
          end else begin
            hi_d = rem_f;
            lo_d = quo_f;
          end
        end
      end
      ST_DONE: begin
        if (flush || resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign stall_req  = (req_valid & ~req_ready) | (resp_valid & ~resp_ready);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: drives two muldiv_unit instances (STEP=1 and STEP=2) with
// identical requests and checks each against an arithmetic reference model.
// Latencies are counted in rising edges after the accepting edge.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, flush;
  logic [1:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        rdy[2], rv[2], rr[2], st[2];
  logic [31:0] hi[2], lo[2];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi, last_lo;

  muldiv_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_op(req_op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_hi(hi[0]), .resp_lo(lo[0]),
    .stall_req(st[0]));

  muldiv_unit #(.WIDTH(32), .STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_op(req_op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_hi(hi[1]), .resp_lo(lo[1]),
    .stall_req(st[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend's sign, matching the HI/LO rules.
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint sa, sb;
    logic [63:0] r64, q64;
    sa = $signed(a);
    sb = $signed(b);
    if (op[1] && b == 32'd0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
    end else begin
      case (op)
        2'd0: r64 = sa * sb;
        2'd1: r64 = {32'd0, a} * {32'd0, b};
        2'd2: begin q64 = sa / sb; r64 = {sa % sb}; r64 = {r64[31:0], q64[31:0]}; end
        default: begin q64 = {32'd0, a} / {32'd0, b}; r64 = {32'd0, a} % {32'd0, b};
                       r64 = {r64[31:0], q64[31:0]}; end
      endcase
      ehi = r64[63:32];
      elo = r64[31:0];
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b, input int d);
    if (op[1] && b == 32'd0) return 1;
    if (!op[1] && FAST) return 1;
    return 32 / (d + 1) + 1;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit release_it);
    bit seen[2];
    int lat[2];
    model(op, a, b, last_hi, last_lo);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    // operands may change freely once accepted
    req_valid = 1'b0; src_a = $urandom; src_b = $urandom; req_op = 2'($urandom);
    seen = '{1'b0, 1'b0};
    lat  = '{0, 0};
    for (int c = 1; c <= 100 && !(seen[0] && seen[1]); c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        if (!seen[d] && rv[d]) begin seen[d] = 1'b1; lat[d] = c; end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (!seen[d] || lat[d] != exp_lat(op, b, d)) begin
        errors++;
        $display("FAIL latency dut%0d op=%0d a=%h b=%h got=%0d seen=%0d want=%0d",
                 d, op, a, b, lat[d], seen[d], exp_lat(op, b, d));
      end
      checks++;
      if (hi[d] !== last_hi) begin
        errors++;
        $display("FAIL resp_hi dut%0d op=%0d a=%h b=%h got=%h want=%h", d, op, a, b, hi[d], last_hi);
      end
      checks++;
      if (lo[d] !== last_lo) begin
        errors++;
        $display("FAIL resp_lo dut%0d op=%0d a=%h b=%h got=%h want=%h", d, op, a, b, lo[d], last_lo);
      end
    end
    if (release_it) begin
      @(negedge clk); rr[0] = 1'b1; rr[1] = 1'b1;
      @(posedge clk); #1; rr[0] = 1'b0; rr[1] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; req_op = 2'd0;
    src_a = '0; src_b = '0; rr[0] = 1'b0; rr[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rv[d], rdy[d], st[d], hi[d], lo[d]} !== {1'b0, 1'b1, 1'b0, 64'd0}) begin
        errors++;
        $display("FAIL reset dut%0d got rv=%b rdy=%b st=%b hi=%h lo=%h want 0 1 0 0 0",
                 d, rv[d], rdy[d], st[d], hi[d], lo[d]);
      end
    end
  endtask

  task automatic test_mul();
    run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    run_op(2'd0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op(2'd0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    for (int i = 0; i < 12; i++)
      run_op(2'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
  endtask

  task automatic test_div();
    logic [31:0] b;
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    run_op(2'd3, 32'd7, 32'd2, 1'b1);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 14; i++) begin
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if ($urandom_range(0, 1)) b = -b;
      run_op(2'($urandom_range(2, 3)), $urandom, b, 1'b1);
    end
  endtask

  task automatic test_div_boundary();
    run_op(2'd3, 32'd5, 32'd0, 1'b1);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(2'd2, 32'h8000_0000, 32'h0000_0001, 1'b1);
  endtask

  task automatic test_flush();
    bit rose;
    // flush mid-divide
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || rv[d] !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle dut%0d got rdy=%b rv=%b want 1 0", d, rdy[d], rv[d]);
      end
    end
    @(negedge clk); flush = 1'b0;
    rose = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rv[0] || rv[1]) rose = 1'b1; end
    checks++;
    if (rose !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_resp got resp_valid=1 want 0");
    end
    // flush in IDLE beats a simultaneous request
    @(negedge clk); req_valid = 1'b1; flush = 1'b1; req_op = 2'd3; src_b = 32'd3;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL flush_blocks_req dut%0d got rdy=%b want 1", d, rdy[d]);
      end
    end
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;
    run_op(2'd1, 32'd3, 32'd4, 1'b1);
  endtask

  task automatic test_backpressure();
    run_op(2'd2, $urandom, 32'($urandom_range(1, 99)), 1'b0);
    @(negedge clk); req_valid = 1'b1; req_op = 2'd1; src_a = $urandom; src_b = $urandom;
    repeat (4) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({rv[d], rdy[d], st[d], hi[d], lo[d]} !== {1'b1, 1'b0, 1'b1, last_hi, last_lo}) begin
          errors++;
          $display("FAIL backpressure dut%0d got rv=%b rdy=%b st=%b hi=%h lo=%h want 1 0 1 %h %h",
                   d, rv[d], rdy[d], st[d], hi[d], lo[d], last_hi, last_lo);
        end
      end
    end
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rv[d] !== 1'b0 || rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL flush_done dut%0d got rv=%b rdy=%b want 0 1", d, rv[d], rdy[d]);
      end
    end
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    run_op(2'd1, 32'd9, 32'd9, 1'b1);  // leave non-zero results in the output regs
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; src_a = 32'd12345; src_b = 32'd11;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rv[d], hi[d], lo[d]} !== {1'b0, 64'd0}) begin
        errors++;
        $display("FAIL reset_mid dut%0d got rv=%b hi=%h lo=%h want 0 0 0", d, rv[d], hi[d], lo[d]);
      end
    end
    @(negedge clk); rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_ready dut%0d got %b want 1", d, rdy[d]);
      end
    end
    run_op(2'd3, 32'd100, 32'd7, 1'b1);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_boundary();
    test_flush();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
